// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 / exception-commit unit: exception codes,
// {rd, sel} register addresses, Status/Cause write masks, wb_exc bit
// positions and the redirect FSM state type.
package cp0_pkg;

  // ExcCode values written into Cause[6:2]
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // CP0 register addresses as {rd, sel}
  localparam logic [7:0] ADDR_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] ADDR_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] ADDR_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] ADDR_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] ADDR_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] ADDR_EPC      = {5'd14, 3'd0};

  // Status: BEV is hard-wired to 1, only IM/EXL/IE are software visible
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
  // Cause: only the two software interrupt pending bits are writable
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  // Bit positions inside wb_exc = {ades, adel, brk, sys, ov, ri, adel_if}
  localparam int WB_ADEL_IF = 0;
  localparam int WB_RI      = 1;
  localparam int WB_OV      = 2;
  localparam int WB_SYS     = 3;
  localparam int WB_BRK     = 4;
  localparam int WB_ADEL    = 5;
  localparam int WB_ADES    = 6;

  typedef enum logic {
    ST_IDLE,
    ST_PEND
  } redir_state_t;

  // Fixed priority: interrupt first, then fetch error, then decode/execute
  // faults, then data-side address errors.
  function automatic logic [4:0] exc_code_of(input logic int_req, input logic [6:0] exc);
    logic [4:0] code;
    code = EXC_INT;
    if (int_req)              code = EXC_INT;
    else if (exc[WB_ADEL_IF]) code = EXC_ADEL;
    else if (exc[WB_RI])      code = EXC_RI;
    else if (exc[WB_OV])      code = EXC_OV;
    else if (exc[WB_SYS])     code = EXC_SYS;
    else if (exc[WB_BRK])     code = EXC_BP;
    else if (exc[WB_ADEL])    code = EXC_ADEL;
    else if (exc[WB_ADES])    code = EXC_ADES;
    return code;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with a prescaler: Count advances once every
// COUNT_DIV clocks and TI latches when the incremented Count meets Compare.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic        tick,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

  logic [PW-1:0] presc;
  logic [31:0]   count_next;

  assign tick       = (presc == PRESC_MAX);
  assign count_next = count + 32'd1;

  // Prescaler wraps on tick; a software Count write restarts the period
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                presc <= '0;
    else if (count_we || tick) presc <= '0;
    else                      presc <= presc + PW'(1);
  end

  // Count: a software write takes precedence over a same-cycle tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         count <= '0;
    else if (count_we) count <= wdata;
    else if (tick)     count <= count_next;
  end

  // Compare register, software written only
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           compare <= '0;
    else if (compare_we) compare <= wdata;
  end

  // TI: writing Compare clears it even if a match happens the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                           ti <= 1'b0;
    else if (compare_we)                                 ti <= 1'b0;
    else if (tick && !count_we && count_next == compare) ti <= 1'b1;
  end

endmodule

// File: rtl/cp0_exc_unit.sv
// Writeback-stage CP0: holds Status/Cause/EPC/BadVAddr plus the timer,
// prioritises exceptions and interrupts on the committing instruction,
// pulses cancel and holds a fetch redirect until fetch accepts it.
module cp0_exc_unit
  import cp0_pkg::*;
#(
  parameter int          HW_INT_NUM      = 6,
  parameter logic [31:0] EXC_VECTOR      = 32'hbfc00380,
  parameter int          COUNT_DIV       = 2,
  parameter int          INT_SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_valid,
  input  logic [31:0]           wb_pc,
  input  logic                  wb_bd,
  input  logic [6:0]            wb_exc,
  input  logic [31:0]           wb_badvaddr,
  input  logic                  wb_eret,
  input  logic                  wb_mtc0,
  input  logic                  wb_mfc0,
  input  logic [7:0]            wb_cp0_addr,
  input  logic [31:0]           wb_wdata,
  output logic [31:0]           cp0_rdata,
  input  logic [HW_INT_NUM-1:0] ext_int,
  output logic                  cancel,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  input  logic                  redirect_ready,
  output logic [31:0]           status,
  output logic [31:0]           cause,
  output logic [31:0]           epc
);

  redir_state_t state;

  logic [INT_SYNC_STAGES-1:0][HW_INT_NUM-1:0] sync_q;
  logic [HW_INT_NUM-1:0] int_sync;
  logic [5:0]  hw_ip;
  logic [7:0]  ip;

  logic [7:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [4:0]  exc_code;
  logic [1:0]  ip_sw;
  logic [31:0] epc_q;
  logic [31:0] badvaddr;

  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;
  logic        timer_tick;

  logic        commit_valid;
  logic        int_req;
  logic        take_exc;
  logic        event_any;
  logic        exc_event;
  logic        eret_event;
  logic        mtc0_en;
  logic [4:0]  code_sel;
  logic [31:0] target_pc;

  // Interrupt line synchroniser chain, oldest stage feeds Cause.IP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= ext_int;
      for (int i = 1; i < INT_SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign int_sync = sync_q[INT_SYNC_STAGES-1];

  // Spread the configured lines over IP[7:2]; absent lines read 0
  always_comb begin
    hw_ip = '0;
    for (int i = 0; i < HW_INT_NUM; i++) hw_ip[i] = int_sync[i];
  end

  assign ip     = {ti | hw_ip[5], hw_ip[4:0], ip_sw};
  assign status = STATUS_RESET | {16'h0, im, 6'h0, exl, ie};
  assign cause  = {bd, ti, 14'h0, ip, 1'b0, exc_code, 2'b00};
  assign epc    = epc_q;

  assign int_req      = (|(ip & im)) & ie & ~exl;
  assign commit_valid = wb_valid && (state == ST_IDLE);
  assign take_exc     = int_req || (|wb_exc);
  assign event_any    = commit_valid && (take_exc || wb_eret);
  assign exc_event    = commit_valid && take_exc;
  assign eret_event   = event_any && !take_exc;
  assign mtc0_en      = commit_valid && wb_mtc0 && !event_any;
  assign code_sel     = exc_code_of(int_req, wb_exc);
  assign target_pc    = take_exc ? EXC_VECTOR : epc_q;
  assign cancel       = event_any;

  // Status fields: exception entry sets EXL, eret clears it, else mtc0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im  <= '0;
      exl <= 1'b0;
      ie  <= 1'b0;
    end else if (exc_event) begin
      exl <= 1'b1;
    end else if (eret_event) begin
      exl <= 1'b0;
    end else if (mtc0_en && wb_cp0_addr == ADDR_STATUS) begin
      im  <= wb_wdata[15:8] & STATUS_WMASK[15:8];
      exl <= wb_wdata[1];
      ie  <= wb_wdata[0];
    end
  end

  // Cause BD/ExcCode on exception entry, software IP bits on mtc0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bd       <= 1'b0;
      exc_code <= '0;
      ip_sw    <= '0;
    end else if (exc_event) begin
      bd       <= wb_bd;
      exc_code <= code_sel;
    end else if (mtc0_en && wb_cp0_addr == ADDR_CAUSE) begin
      ip_sw <= wb_wdata[9:8] & CAUSE_WMASK[9:8];
    end
  end

  // EPC points at the branch when the faulting instruction is in its slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        epc_q <= '0;
    else if (exc_event)                               epc_q <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
    else if (mtc0_en && wb_cp0_addr == ADDR_EPC)      epc_q <= wb_wdata;
  end

  // BadVAddr only follows the winning address-error exception
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      badvaddr <= '0;
    end else if (exc_event && !int_req) begin
      if (wb_exc[WB_ADEL_IF])                               badvaddr <= wb_pc;
      else if (code_sel == EXC_ADEL || code_sel == EXC_ADES) badvaddr <= wb_badvaddr;
    end
  end

  // Redirect handshake: latch the target on commit, hold until accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (event_any) begin
            state          <= ST_PEND;
            redirect_valid <= 1'b1;
            redirect_pc    <= target_pc;
          end
        end
        ST_PEND: begin
          if (redirect_ready) begin
            state          <= ST_IDLE;
            redirect_valid <= 1'b0;
          end
        end
        default: begin
          state          <= ST_IDLE;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (mtc0_en && wb_cp0_addr == ADDR_COUNT),
    .compare_we (mtc0_en && wb_cp0_addr == ADDR_COMPARE),
    .wdata      (wb_wdata),
    .tick       (timer_tick),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  // mfc0 read mux, returns the value held before this cycle's edge
  always_comb begin
    cp0_rdata = '0;
    if (wb_mfc0) begin
      case (wb_cp0_addr)
        ADDR_BADVADDR: cp0_rdata = badvaddr;
        ADDR_COUNT:    cp0_rdata = count;
        ADDR_COMPARE:  cp0_rdata = compare;
        ADDR_STATUS:   cp0_rdata = status;
        ADDR_CAUSE:    cp0_rdata = cause;
        ADDR_EPC:      cp0_rdata = epc_q;
        default:       cp0_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Bench for cp0_exc_unit: directed scenarios followed by a random phase,
// all checked every cycle against a behavioural model of the CP0 rules.
module tb_cp0_exc_unit;

  localparam int          HW   = 6;
  localparam int          DIV  = 2;
  localparam int          SYNC = 2;
  localparam logic [31:0] VEC  = 32'hbfc00380;

  localparam logic [7:0] A_BADV = {5'd8,  3'd0};
  localparam logic [7:0] A_CNT  = {5'd9,  3'd0};
  localparam logic [7:0] A_CMP  = {5'd11, 3'd0};
  localparam logic [7:0] A_STS  = {5'd12, 3'd0};
  localparam logic [7:0] A_CAU  = {5'd13, 3'd0};
  localparam logic [7:0] A_EPC  = {5'd14, 3'd0};

  // ExcCode for each wb_exc bit; lower bit index means higher priority
  localparam logic [4:0] CODE_OF_BIT [7] = '{5'd4, 5'd10, 5'd12, 5'd8, 5'd9, 5'd4, 5'd5};

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, wb_bd, wb_eret, wb_mtc0, wb_mfc0, redirect_ready;
  logic [31:0] wb_pc, wb_badvaddr, wb_wdata;
  logic [6:0]  wb_exc;
  logic [7:0]  wb_cp0_addr;
  logic [HW-1:0] ext_int;
  logic [31:0] cp0_rdata, redirect_pc, status, cause, epc;
  logic        cancel, redirect_valid;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  logic [7:0]  m_im;
  logic        m_ie, m_exl, m_bd, m_ti, m_pend;
  logic [4:0]  m_code;
  logic [1:0]  m_ipsw;
  logic [31:0] m_epc, m_bad, m_cbase, m_compare, m_rpc;
  int unsigned m_cyc;
  logic [5:0]  m_extq[$];

  always #5 clk = ~clk;

  cp0_exc_unit #(
    .HW_INT_NUM      (HW),
    .EXC_VECTOR      (VEC),
    .COUNT_DIV       (DIV),
    .INT_SYNC_STAGES (SYNC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .wb_valid       (wb_valid),
    .wb_pc          (wb_pc),
    .wb_bd          (wb_bd),
    .wb_exc         (wb_exc),
    .wb_badvaddr    (wb_badvaddr),
    .wb_eret        (wb_eret),
    .wb_mtc0        (wb_mtc0),
    .wb_mfc0        (wb_mfc0),
    .wb_cp0_addr    (wb_cp0_addr),
    .wb_wdata       (wb_wdata),
    .cp0_rdata      (cp0_rdata),
    .ext_int        (ext_int),
    .cancel         (cancel),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .status         (status),
    .cause          (cause),
    .epc            (epc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_count();
    return m_cbase + 32'(m_cyc / DIV);
  endfunction

  function automatic logic [7:0] m_ip();
    logic [5:0] s;
    s = m_extq[0];
    return {m_ti | s[5], s[4:0], m_ipsw};
  endfunction

  function automatic logic [31:0] m_status();
    return 32'h0040_0000 + {16'h0, m_im, 8'h0} + {30'h0, m_exl, m_ie};
  endfunction

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'h0, m_ip(), 1'b0, m_code, 2'b00};
  endfunction

  function automatic logic m_intreq();
    return (|(m_ip() & m_im)) && m_ie && !m_exl;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      A_BADV:  return m_bad;
      A_CNT:   return m_count();
      A_CMP:   return m_compare;
      A_STS:   return m_status();
      A_CAU:   return m_cause();
      A_EPC:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_reset();
    m_im = '0; m_ie = 0; m_exl = 0; m_bd = 0; m_ti = 0; m_pend = 0;
    m_code = '0; m_ipsw = '0; m_epc = '0; m_bad = '0; m_cbase = '0;
    m_compare = '0; m_rpc = '0; m_cyc = 0;
    m_extq.delete();
    for (int i = 0; i < SYNC; i++) m_extq.push_back(6'h0);
  endfunction

  // Compare every observable output with what the model predicts now
  task automatic checkOutput();
    logic v, take, ev;
    v    = wb_valid && !m_pend;
    take = m_intreq() || (|wb_exc);
    ev   = v && (take || wb_eret);
    check("cancel",         {31'h0, cancel},         {31'h0, ev});
    check("redirect_valid", {31'h0, redirect_valid}, {31'h0, m_pend});
    check("redirect_pc",    redirect_pc,             m_rpc);
    check("status",         status,                  m_status());
    check("cause",          cause,                   m_cause());
    check("epc",            epc,                     m_epc);
    check("cp0_rdata",      cp0_rdata,               wb_mfc0 ? m_read(wb_cp0_addr) : 32'h0);
  endtask

  // Advance the model across one rising edge using the current inputs
  task automatic modelEdge();
    logic v, ireq, take, ev, mt, tick;
    int first;
    logic [31:0] old_epc;
    v       = wb_valid && !m_pend;
    ireq    = m_intreq();
    take    = ireq || (|wb_exc);
    ev      = v && (take || wb_eret);
    mt      = v && wb_mtc0 && !ev;
    old_epc = m_epc;
    first   = -1;
    for (int b = 6; b >= 0; b--) if (wb_exc[b]) first = b;

    if (m_pend) begin
      if (redirect_ready) m_pend = 0;
    end else if (ev) begin
      m_pend = 1;
      m_rpc  = take ? VEC : old_epc;
    end

    if (ev && take) begin
      m_bd   = wb_bd;
      m_code = ireq ? 5'd0 : CODE_OF_BIT[first];
      m_epc  = wb_bd ? wb_pc - 32'd4 : wb_pc;
      m_exl  = 1;
      if (!ireq && first == 0) m_bad = wb_pc;
      else if (!ireq && (first == 5 || first == 6)) m_bad = wb_badvaddr;
    end else if (ev) begin
      m_exl = 0;
    end else if (mt) begin
      if (wb_cp0_addr == A_STS) begin
        m_im = wb_wdata[15:8]; m_exl = wb_wdata[1]; m_ie = wb_wdata[0];
      end
      if (wb_cp0_addr == A_CAU) m_ipsw = wb_wdata[9:8];
      if (wb_cp0_addr == A_EPC) m_epc = wb_wdata;
    end

    tick = ((m_cyc + 1) % DIV) == 0;
    if (mt && wb_cp0_addr == A_CNT) begin
      m_cbase = wb_wdata; m_cyc = 0; tick = 0;
    end else begin
      m_cyc++;
    end
    if (mt && wb_cp0_addr == A_CMP) begin
      m_compare = wb_wdata; m_ti = 0;
    end else if (tick && m_count() == m_compare) begin
      m_ti = 1;
    end

    m_extq.push_back(6'(ext_int));
    void'(m_extq.pop_front());
  endtask

  // Drive one cycle of WB inputs, check, and move to the next cycle
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic bd,
                               input logic [6:0] exc, input logic eret, input logic mtc0,
                               input logic mfc0, input logic [7:0] addr,
                               input logic [31:0] wdata, input logic ready);
    wb_valid = v; wb_pc = pc; wb_bd = bd; wb_exc = exc; wb_eret = eret;
    wb_mtc0 = mtc0; wb_mfc0 = mfc0; wb_cp0_addr = addr; wb_wdata = wdata;
    wb_badvaddr = pc ^ 32'h0000_0ff1; redirect_ready = ready;
    #1;
    checkOutput();
    modelEdge();
    @(negedge clk);
  endtask

  task automatic idle(input logic ready);
    applyStimulus(0, 32'h0, 0, 7'h0, 0, 0, 0, 8'h0, 32'h0, ready);
  endtask

  task automatic mtc0w(input logic [7:0] addr, input logic [31:0] data);
    applyStimulus(1, 32'h8000_0400, 0, 7'h0, 0, 1, 0, addr, data, 0);
  endtask

  task automatic mfc0r(input logic [7:0] addr);
    applyStimulus(1, 32'h8000_0500, 0, 7'h0, 0, 0, 1, addr, 32'h0, 0);
  endtask

  initial begin
    reset = 1; ext_int = '0;
    wb_valid = 0; wb_pc = '0; wb_bd = 0; wb_exc = '0; wb_eret = 0; wb_mtc0 = 0;
    wb_mfc0 = 0; wb_cp0_addr = '0; wb_wdata = '0; wb_badvaddr = '0; redirect_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    checkOutput();
    check("reset_status", status, 32'h0040_0000);
    @(negedge clk);
    reset = 0;

    // Syscall, redirect accepted on the third pending cycle
    applyStimulus(1, 32'h8000_1000, 0, 7'b0001000, 0, 0, 0, 8'h0, 32'h0, 0);
    check("sys_code", {27'h0, cause[6:2]}, 32'd8);
    check("sys_epc", epc, 32'h8000_1000);
    check("sys_exl", {31'h0, status[1]}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      check("sys_rv_held", {31'h0, redirect_valid}, 32'd1);
      check("sys_rpc", redirect_pc, 32'hbfc0_0380);
      idle(k == 2);
    end
    check("sys_rv_fall", {31'h0, redirect_valid}, 32'd0);

    // Delay slot with ri and ov together
    applyStimulus(1, 32'h8000_0104, 1, 7'b0000110, 0, 0, 0, 8'h0, 32'h0, 0);
    check("bd_code", {27'h0, cause[6:2]}, 32'd10);
    check("bd_bit", {31'h0, cause[31]}, 32'd1);
    check("bd_epc", epc, 32'h8000_0100);
    idle(1);

    // Unaligned fetch
    applyStimulus(1, 32'h8000_0002, 0, 7'b0000001, 0, 0, 0, 8'h0, 32'h0, 0);
    check("if_code", {27'h0, cause[6:2]}, 32'd4);
    idle(1);
    wb_mfc0 = 1; wb_cp0_addr = A_BADV; #1;
    check("if_badv", cp0_rdata, 32'h8000_0002);
    mfc0r(A_BADV);

    // Timer interrupt
    mtc0w(A_STS, 32'h0000_8001);
    mtc0w(A_CMP, 32'd5);
    mtc0w(A_CNT, 32'd0);
    repeat (9) idle(0);
    check("ti_early", {31'h0, cause[30]}, 32'd0);
    idle(0);
    check("ti_set", {31'h0, cause[30]}, 32'd1);
    check("ip7_set", {31'h0, cause[15]}, 32'd1);
    applyStimulus(1, 32'h8000_2000, 0, 7'h0, 0, 0, 0, 8'h0, 32'h0, 0);
    check("ti_code", {27'h0, cause[6:2]}, 32'd0);
    check("ti_epc", epc, 32'h8000_2000);
    idle(1);
    mtc0w(A_CMP, 32'h0);
    check("ti_clear", {31'h0, cause[30]}, 32'd0);

    // External interrupt then eret
    mtc0w(A_STS, 32'h0000_0401);
    ext_int = 6'b000001;
    idle(0);
    idle(0);
    check("ip2_set", {31'h0, cause[10]}, 32'd1);
    applyStimulus(1, 32'h8000_3000, 0, 7'h0, 0, 0, 0, 8'h0, 32'h0, 0);
    check("ext_code", {27'h0, cause[6:2]}, 32'd0);
    idle(1);
    ext_int = '0;
    repeat (3) idle(0);
    applyStimulus(1, 32'h8000_3100, 0, 7'h0, 1, 0, 0, 8'h0, 32'h0, 0);
    check("eret_rpc", redirect_pc, 32'h8000_3000);
    check("eret_exl", {31'h0, status[1]}, 32'd0);
    idle(1);

    // Reset while a redirect is pending
    applyStimulus(1, 32'h8000_4000, 0, 7'b0001000, 0, 0, 0, 8'h0, 32'h0, 0);
    check("pend_rv", {31'h0, redirect_valid}, 32'd1);
    reset = 1; #1;
    model_reset();
    check("rst_rv", {31'h0, redirect_valid}, 32'd0);
    check("rst_status", status, 32'h0040_0000);
    checkOutput();
    @(negedge clk);
    reset = 0;

    // Random phase
    for (int n = 0; n < 800; n++) begin
      logic [7:0] addr_list [8];
      logic [6:0] exc;
      logic       er, mt, mf, v;
      logic [7:0] a;
      logic [31:0] wd;
      int r;
      addr_list = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h78, 8'h00};
      if ($urandom % 25 == 0) ext_int = ext_int ^ (6'd1 << ($urandom % 6));
      v = ($urandom % 4) != 0;
      r = int'($urandom % 16);
      exc = '0; er = 0; mt = 0;
      if (r < 2) exc = (7'd1 << ($urandom % 7)) | ((($urandom % 3) == 0) ? 7'(1 << ($urandom % 7)) : 7'd0);
      else if (r == 2) er = 1;
      else if (r < 8) mt = 1;
      mf = ($urandom % 2) == 1;
      a  = addr_list[$urandom % 8];
      wd = $urandom;
      if (mt && a == A_CMP) wd = m_count() + 32'($urandom % 6);
      applyStimulus(v, $urandom & 32'hffff_fffc, 1'($urandom % 2), exc, er, mt, mf, a, wd,
                    ($urandom % 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
